// File: rtl/spu_pkg.sv
// Shared SPU definitions: datapath widths, writeback queue depth and the
// writeback entry layout.
package spu_pkg;

    localparam int DATA_W     = 128;
    localparam int REG_ADDR_W = 7;
    localparam int WB_DEPTH   = 4;
    localparam int ZMASK_W    = DATA_W / 16;

    typedef struct packed {
        logic [DATA_W-1:0]     data;
        logic [REG_ADDR_W-1:0] dest;
        logic [ZMASK_W-1:0]    zmask;
    } wb_entry_t;

endpackage

// File: rtl/simd_zero_mask.sv
// Per-halfword-lane zero flags for a SIMD result quadword. In fullword mode
// each 32-bit word drives the pair of flags covering its two halfwords.
module simd_zero_mask
    import spu_pkg::*;
(
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_half,
    output logic [ZMASK_W-1:0] zmask
);

    // Flag generation: one bit per halfword lane, lane width chosen by in_half
    always_comb begin
        zmask = '0;
        for (int i = 0; i < ZMASK_W; i++) begin
            if (in_half) begin
                zmask[i] = (in_data[16*i +: 16] == 16'h0000);
            end else begin
                zmask[i] = (in_data[32*(i/2) +: 32] == 32'h0000_0000);
            end
        end
    end

endmodule

// File: rtl/simd_writeback_queue.sv
// Writeback queue between the SIMD ALU and the register file. Results are
// buffered in a circular FIFO, written back in push order, and every queued
// entry is searchable for operand forwarding (youngest match wins).
// DEPTH must be a power of two, at least 2, so the pointers wrap naturally.
module simd_writeback_queue
    import spu_pkg::*;
#(
    parameter int DEPTH  = WB_DEPTH,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [ADDR_W-1:0]        in_dest,
    input  logic                     in_half,
    output logic                     rf_we,
    input  logic                     rf_ack,
    output logic [ADDR_W-1:0]        rf_waddr,
    output logic [DATA_W-1:0]        rf_wdata,
    output logic [ZMASK_W-1:0]       rf_zmask,
    input  logic [ADDR_W-1:0]        fwd_addr,
    output logic                     fwd_hit,
    output logic [DATA_W-1:0]        fwd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Entry storage is never reset; validity is tracked by the pointers/count.
    logic [DATA_W-1:0]  data_mem  [DEPTH];
    logic [ADDR_W-1:0]  dest_mem  [DEPTH];
    logic [ZMASK_W-1:0] zmask_mem [DEPTH];

    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count_q;

    logic [ZMASK_W-1:0] push_zmask;
    logic               do_push;
    logic               do_pop;

    simd_zero_mask u_zero_mask (
        .in_data (in_data),
        .in_half (in_half),
        .zmask   (push_zmask)
    );

    // Handshakes: a full queue refuses input even when the head pops this cycle
    assign in_ready = (count_q < FULL_CNT);
    assign rf_we    = (count_q != '0);
    assign do_push  = in_valid && in_ready;
    assign do_pop   = rf_we && rf_ack;
    assign count    = count_q;

    // Head entry presented to the register file
    assign rf_waddr = dest_mem[rd_ptr];
    assign rf_wdata = data_mem[rd_ptr];
    assign rf_zmask = zmask_mem[rd_ptr];

    // Control state: pointers and occupancy, cleared by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage: written at the write pointer on every accepted push
    always_ff @(posedge clk) begin
        if (do_push) begin
            data_mem[wr_ptr]  <= in_data;
            dest_mem[wr_ptr]  <= in_dest;
            zmask_mem[wr_ptr] <= push_zmask;
        end
    end

    // Forwarding: walk valid entries oldest to youngest so the youngest match
    // is the one left standing; the head still counts while it pops
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < count_q) &&
                (dest_mem[rd_ptr + PTR_W'(i)] == fwd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_mem[rd_ptr + PTR_W'(i)];
            end
        end
    end

endmodule

// File: tb/tb_simd_writeback_queue.sv
// Testbench for simd_writeback_queue: a stimulus process drives one cycle at a
// time and keeps a queue-level reference model; a monitor process compares
// DUT outputs against the model's expectations and pops expected writes from
// a scoreboard whenever the DUT performs a register-file write.
module tb_simd_writeback_queue;
    import spu_pkg::*;

    localparam int DEPTH = WB_DEPTH;

    logic                  clk;
    logic                  rst_n;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     in_data;
    logic [REG_ADDR_W-1:0] in_dest;
    logic                  in_half;
    logic                  rf_we;
    logic                  rf_ack;
    logic [REG_ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0]     rf_wdata;
    logic [ZMASK_W-1:0]    rf_zmask;
    logic [REG_ADDR_W-1:0] fwd_addr;
    logic                  fwd_hit;
    logic [DATA_W-1:0]     fwd_data;
    logic [$clog2(DEPTH):0] count;

    simd_writeback_queue #(.DEPTH(DEPTH), .ADDR_W(REG_ADDR_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_dest  (in_dest),
        .in_half  (in_half),
        .rf_we    (rf_we),
        .rf_ack   (rf_ack),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .rf_zmask (rf_zmask),
        .fwd_addr (fwd_addr),
        .fwd_hit  (fwd_hit),
        .fwd_data (fwd_data),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: entries currently held, plus writes not yet observed
    wb_entry_t mdl[$];
    wb_entry_t sb[$];
    bit        known = 0;

    // Expectations for the current cycle, set by the stimulus process
    bit                snap_ok = 0;
    int                exp_cnt;
    bit                exp_rdy;
    bit                exp_we;
    bit                exp_hit;
    logic [DATA_W-1:0] exp_fd;

    task automatic check(input string nm, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [ZMASK_W-1:0] ref_zmask(input logic [DATA_W-1:0] d,
                                                      input logic half);
        logic [ZMASK_W-1:0] m;
        m = '0;
        if (half) begin
            for (int i = 0; i < 8; i++)
                m[i] = (((d >> (16 * i)) & 128'hFFFF) == 0);
        end else begin
            for (int w = 0; w < 4; w++) begin
                if (((d >> (32 * w)) & 128'hFFFF_FFFF) == 0) begin
                    m[2*w]   = 1'b1;
                    m[2*w+1] = 1'b1;
                end
            end
        end
        return m;
    endfunction

    // One clock cycle of stimulus: drive inputs, record this cycle's
    // expectations, then advance the model past the coming rising edge.
    task automatic cycle(input logic r, input logic v, input logic [DATA_W-1:0] d,
                         input logic [REG_ADDR_W-1:0] a, input logic h,
                         input logic ack, input logic [REG_ADDR_W-1:0] fa);
        wb_entry_t e;
        bit        will_pop;
        bit        will_push;
        @(negedge clk);
        rst_n    = r;
        in_valid = v;
        in_data  = d;
        in_dest  = a;
        in_half  = h;
        rf_ack   = ack;
        fwd_addr = fa;
        if (known) begin
            exp_cnt = mdl.size();
            exp_rdy = (mdl.size() < DEPTH);
            exp_we  = (mdl.size() != 0);
            exp_hit = 1'b0;
            exp_fd  = '0;
            for (int i = mdl.size() - 1; i >= 0; i--) begin
                if (mdl[i].dest == fa) begin
                    exp_hit = 1'b1;
                    exp_fd  = mdl[i].data;
                    break;
                end
            end
            snap_ok = 1;
        end else begin
            snap_ok = 0;
        end
        if (!r) begin
            mdl.delete();
            sb.delete();
            known = 1;
        end else if (known) begin
            will_pop  = ack && (mdl.size() > 0);
            will_push = v && (mdl.size() < DEPTH);
            if (will_pop) void'(mdl.pop_front());
            if (will_push) begin
                e.data  = d;
                e.dest  = a;
                e.zmask = ref_zmask(d, h);
                mdl.push_back(e);
                sb.push_back(e);
            end
        end
    endtask

    task automatic idle(input logic ack, input logic [REG_ADDR_W-1:0] fa);
        cycle(1'b1, 1'b0, '0, '0, 1'b0, ack, fa);
    endtask

    function automatic logic [DATA_W-1:0] rand_data();
        logic [DATA_W-1:0] d;
        for (int j = 0; j < 8; j++)
            d[16*j +: 16] = ($urandom_range(0, 2) == 0) ? 16'h0 : 16'($urandom);
        return d;
    endfunction

    // Monitor: mid-cycle comparison of every observable output
    initial begin
        wb_entry_t e;
        forever begin
            @(negedge clk);
            #2;
            if (snap_ok) begin
                check("count", DATA_W'(count), DATA_W'(exp_cnt));
                check("in_ready", DATA_W'(in_ready), DATA_W'(exp_rdy));
                check("rf_we", DATA_W'(rf_we), DATA_W'(exp_we));
                check("fwd_hit", DATA_W'(fwd_hit), DATA_W'(exp_hit));
                check("fwd_data", fwd_data, exp_fd);
                if (rf_we && rf_ack && rst_n) begin
                    if (sb.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL wr_unexpected: got write to %0d expected none", rf_waddr);
                    end else begin
                        e = sb.pop_front();
                        check("rf_waddr", DATA_W'(rf_waddr), DATA_W'(e.dest));
                        check("rf_wdata", rf_wdata, e.data);
                        check("rf_zmask", DATA_W'(rf_zmask), DATA_W'(e.zmask));
                    end
                end
            end
        end
    end

    // Stimulus
    initial begin
        logic [DATA_W-1:0] da;
        logic [DATA_W-1:0] db;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_dest = '0;
        in_half = 1'b0; rf_ack = 1'b0; fwd_addr = '0;

        // Reset and state right after reset
        cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0);
        idle(1'b0, 7'd0);
        #3;
        check("rst_count", DATA_W'(count), '0);
        check("rst_ready", DATA_W'(in_ready), 1);
        check("rst_we", DATA_W'(rf_we), '0);
        check("rst_fwd_hit", DATA_W'(fwd_hit), '0);

        // Single halfword push, written the following cycle
        cycle(1'b1, 1'b1, 128'h0001_0000, 7'd5, 1'b1, 1'b1, 7'd0);
        idle(1'b1, 7'd0);
        #3;
        check("lat_we", DATA_W'(rf_we), 1);
        check("lat_waddr", DATA_W'(rf_waddr), 5);
        check("lat_zmask", DATA_W'(rf_zmask), 128'hFD);
        idle(1'b0, 7'd0);
        #3;
        check("lat_count", DATA_W'(count), '0);

        // Fill to full, fifth refused, including while the head pops
        for (int i = 1; i <= 4; i++)
            cycle(1'b1, 1'b1, rand_data(), 7'(i), 1'b1, 1'b0, 7'd0);
        cycle(1'b1, 1'b1, rand_data(), 7'd15, 1'b1, 1'b0, 7'd0);
        #3;
        check("full_count", DATA_W'(count), 4);
        check("full_ready", DATA_W'(in_ready), '0);
        cycle(1'b1, 1'b1, rand_data(), 7'd16, 1'b0, 1'b1, 7'd16);
        for (int i = 0; i < 4; i++) idle(1'b1, 7'd0);
        idle(1'b0, 7'd0);
        #3;
        check("drain_count", DATA_W'(count), '0);

        // Steady push+pop at occupancy 2, pointers wrap
        cycle(1'b1, 1'b1, rand_data(), 7'd20, 1'b0, 1'b0, 7'd0);
        cycle(1'b1, 1'b1, rand_data(), 7'd21, 1'b0, 1'b0, 7'd0);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b1, rand_data(), 7'(22 + i), 1'b1, 1'b1, 7'(20 + i));
            #3;
            check("pp_count", DATA_W'(count), 2);
        end
        idle(1'b1, 7'd0);
        idle(1'b1, 7'd0);

        // Forwarding picks the youngest of two matches
        da = {4{32'hAAAA_0001}};
        db = {4{32'hBBBB_0002}};
        cycle(1'b1, 1'b1, da, 7'd9, 1'b0, 1'b0, 7'd0);
        cycle(1'b1, 1'b1, db, 7'd9, 1'b0, 1'b0, 7'd9);
        idle(1'b0, 7'd9);
        #3;
        check("fwd9_hit", DATA_W'(fwd_hit), 1);
        check("fwd9_data", fwd_data, db);
        idle(1'b0, 7'd10);
        #3;
        check("fwd10_hit", DATA_W'(fwd_hit), '0);
        check("fwd10_data", fwd_data, '0);
        idle(1'b1, 7'd9);
        idle(1'b1, 7'd9);

        // Fullword push with word 2 zero
        cycle(1'b1, 1'b1, {32'h1, 32'h0, 32'h2, 32'h3}, 7'd30, 1'b0, 1'b0, 7'd0);
        idle(1'b0, 7'd0);
        #3;
        check("fw_zmask", DATA_W'(rf_zmask), 128'h30);
        idle(1'b1, 7'd0);

        // Reset with three entries queued and a push pending
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 1'b1, rand_data(), 7'(40 + i), 1'b0, 1'b0, 7'd0);
        cycle(1'b0, 1'b1, rand_data(), 7'd50, 1'b1, 1'b1, 7'd40);
        idle(1'b0, 7'd50);
        #3;
        check("rst3_count", DATA_W'(count), '0);
        check("rst3_we", DATA_W'(rf_we), '0);
        check("rst3_ready", DATA_W'(in_ready), 1);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 99) != 0),
                  ($urandom_range(0, 9) < 7),
                  rand_data(),
                  7'($urandom_range(0, 7)),
                  1'($urandom),
                  ($urandom_range(0, 9) < 5),
                  7'($urandom_range(0, 8)));
        end

        // Drain and confirm every expected write was observed
        for (int i = 0; i < DEPTH + 1; i++) idle(1'b1, 7'd0);
        idle(1'b0, 7'd0);
        #3;
        check("final_count", DATA_W'(count), '0);
        check("sb_left", DATA_W'(sb.size()), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
